// File: rtl/netdelay_pkg.sv
// Shared defaults and FSM encoding for the word change capture block.
package netdelay_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        ARMED = 1'b0,
        TRACK = 1'b1
    } state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO holding captured words; no write-to-read bypass.
module word_fifo
    import netdelay_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left uncleared on reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/word_change_capture.sv
// Pushes each newly observed input word into a FIFO, counting changes and flagging drops.
module word_change_capture
    import netdelay_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         change_cnt,
    output logic                     overflow
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_word_q, prev_word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             change;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign change = din_en && ((state_q == ARMED) || (din != prev_word_q));
    assign pop    = !fifo_empty && dout_ready;

    always_comb begin
        state_d     = state_q;
        prev_word_d = prev_word_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        if (change) begin
            state_d     = TRACK;
            prev_word_d = din;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            // A simultaneous pop frees a slot, so only a non-popping full FIFO drops.
            if (fifo_full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARMED;
            prev_word_q <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_word_q <= prev_word_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign dout_valid = !fifo_empty;
    assign change_cnt = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_word_change_capture.sv
// Scoreboard bench for word_change_capture: a reference model predicts FIFO contents and flags.
module tb_word_change_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        din_en = 1'b0;
    logic        dout_ready = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic [2:0]  level;
    logic [15:0] change_cnt;
    logic        overflow;

    logic [31:0] din2 = '0;
    logic        din_en2 = 1'b0;
    logic [31:0] dout2;
    logic        dout_valid2;
    logic [2:0]  level2;
    logic [3:0]  change_cnt2;
    logic        overflow2;

    int passed = 0;
    int total  = 0;

    logic [31:0] sb[$];
    bit          m_track;
    logic [31:0] m_prev;
    int          m_cnt;
    bit          m_ovf;

    always #5 clk = ~clk;

    word_change_capture #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .change_cnt(change_cnt), .overflow(overflow)
    );

    word_change_capture #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .din(din2), .din_en(din_en2),
        .dout(dout2), .dout_valid(dout_valid2), .dout_ready(1'b1),
        .level(level2), .change_cnt(change_cnt2), .overflow(overflow2)
    );

    // Drive one cycle of stimulus and advance the model to the post-edge state.
    task automatic step(input logic r, input logic [31:0] d, input logic e, input logic rd);
        bit pop_m;
        bit chg;
        rst = r; din = d; din_en = e; dout_ready = rd;
        if (r) begin
            sb.delete(); m_track = 0; m_prev = '0; m_cnt = 0; m_ovf = 0;
        end else begin
            pop_m = (sb.size() > 0) && rd;
            chg   = e && (!m_track || d != m_prev);
            if (pop_m) void'(sb.pop_front());
            if (chg) begin
                m_prev = d; m_track = 1;
                if (m_cnt < 65535) m_cnt++;
                if (sb.size() < 4) sb.push_back(d);
                else m_ovf = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(1, '0, 0, 0);
        step(1, 32'h1234, 1, 1);
        total++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dout_valid); else passed++;
        total++; if (dout !== 32'h0) $display("FAIL reset_dout got=%h exp=0", dout); else passed++;
        total++; if (change_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", change_cnt); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else passed++;
    endtask

    task automatic test_first_sample();
        step(0, 32'hFFFF_FFFE, 1, 0);
        total++; if (dout_valid !== 1'b1) $display("FAIL first_valid got=%b exp=1", dout_valid); else passed++;
        total++; if (dout !== sb[0]) $display("FAIL first_dout got=%h exp=%h", dout, sb[0]); else passed++;
        total++; if (change_cnt !== 16'(m_cnt)) $display("FAIL first_cnt got=%0d exp=%0d", change_cnt, m_cnt); else passed++;
    endtask

    task automatic test_repeat();
        for (int i = 0; i < 5; i++) step(0, 32'hFFFF_FFFE, 1, 0);
        total++; if (level !== 3'(sb.size())) $display("FAIL repeat_level got=%0d exp=%0d", level, sb.size()); else passed++;
        total++; if (change_cnt !== 16'(m_cnt)) $display("FAIL repeat_cnt got=%0d exp=%0d", change_cnt, m_cnt); else passed++;
        total++; if (dout !== sb[0]) $display("FAIL repeat_dout got=%h exp=%h", dout, sb[0]); else passed++;
        step(0, '0, 0, 1);
        total++; if (dout_valid !== 1'b0) $display("FAIL repeat_drain got=%b exp=0", dout_valid); else passed++;
    endtask

    task automatic test_overflow();
        step(1, '0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 32'(i), 1, 0);
        total++; if (level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else passed++;
        total++; if (change_cnt !== 16'(m_cnt)) $display("FAIL ovf_cnt got=%0d exp=%0d", change_cnt, m_cnt); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (dout !== sb[0]) $display("FAIL ovf_drain got=%h exp=%h", dout, sb[0]); else passed++;
            step(0, '0, 0, 1);
        end
        total++; if (dout_valid !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", dout_valid); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else passed++;
    endtask

    task automatic test_full_push_pop();
        step(1, '0, 0, 0);
        for (int i = 10; i < 14; i++) step(0, 32'(i), 1, 0);
        total++; if (level !== 3'd4) $display("FAIL fpp_fill got=%0d exp=4", level); else passed++;
        step(0, 32'd14, 1, 1);
        total++; if (level !== 3'(sb.size())) $display("FAIL fpp_level got=%0d exp=%0d", level, sb.size()); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf got=%b exp=0", overflow); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (dout !== sb[0]) $display("FAIL fpp_drain got=%h exp=%h", dout, sb[0]); else passed++;
            step(0, '0, 0, 1);
        end
    endtask

    task automatic test_reset_mid();
        step(1, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'h21 + 32'(i), 1, 0);
        step(0, '0, 0, 1);
        total++; if (level !== 3'd3) $display("FAIL rmid_level got=%0d exp=3", level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL rmid_ovf got=%b exp=1", overflow); else passed++;
        step(1, 32'h99, 1, 1);
        total++; if (level !== 3'd0) $display("FAIL rmid_rlevel got=%0d exp=0", level); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL rmid_rvalid got=%b exp=0", dout_valid); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rmid_rovf got=%b exp=0", overflow); else passed++;
        // Word 0 equals the reset prev_word, so only the ARMED state makes it a change.
        step(0, 32'h0, 1, 0);
        total++; if (dout_valid !== 1'b1) $display("FAIL rmid_armed got=%b exp=1", dout_valid); else passed++;
        total++; if (change_cnt !== 16'(m_cnt)) $display("FAIL rmid_cnt got=%0d exp=%0d", change_cnt, m_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_dout;
        step(1, '0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            step(0, 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0 ? 0 : 1));
            exp_dout = (sb.size() > 0) ? sb[0] : 32'h0;
            total++; if (dout !== exp_dout) $display("FAIL b2b_dout cyc=%0d got=%h exp=%h", i, dout, exp_dout); else passed++;
            total++; if (level !== 3'(sb.size())) $display("FAIL b2b_level cyc=%0d got=%0d exp=%0d", i, level, sb.size()); else passed++;
            total++; if (dout_valid !== (sb.size() > 0)) $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, dout_valid, sb.size() > 0); else passed++;
            total++; if (change_cnt !== 16'(m_cnt)) $display("FAIL b2b_cnt cyc=%0d got=%0d exp=%0d", i, change_cnt, m_cnt); else passed++;
            total++; if (overflow !== m_ovf) $display("FAIL b2b_ovf cyc=%0d got=%b exp=%b", i, overflow, m_ovf); else passed++;
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        step(1, '0, 0, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            din2 = (i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
            din_en2 = 1'b1;
            @(posedge clk); #1;
            exp_cnt = (i + 1 < 15) ? i + 1 : 15;
            total++; if (change_cnt2 !== 4'(exp_cnt)) $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, change_cnt2, exp_cnt); else passed++;
        end
        din_en2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (change_cnt2 !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", change_cnt2); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_repeat();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
